game_credit_arbiter: RTL and testbench

// - Shared cashier and credit scheduler for N game stations on one arcade board.
// - Arbitrates one top-up per cycle among stations (round-robin, valid/ready handshake).
// - Keeps a per-station credit counter with a per-station session FSM; burns credit 1/cycle, 2/cycle when boosted.
// - Drives the per-station low-credit and expiry indicators.

---
 rtl/game_credit_arbiter.sv | 137 +++++++++++++
 tb/tb_game_credit_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/game_credit_arbiter.sv
// Round-robin cashier plus per-station credit counters and session FSMs for an arcade board.
// Optional statistics outputs (revenue, grant_cnt) are enabled with `define GAME_CREDIT_STATS_EN.
module game_credit_arbiter #(
  parameter int N_STATION  = 4,
  parameter int CREDIT_W   = 10,
  parameter int WARN_LEVEL = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_STATION-1:0]          req_valid,
  input  logic [N_STATION*CREDIT_W-1:0] req_money,
  output logic [N_STATION-1:0]          req_ready,
  input  logic [N_STATION-1:0]          boost,
  output logic [N_STATION*CREDIT_W-1:0] credit,
  output logic [N_STATION*2-1:0]        state,
  output logic [N_STATION-1:0]          low,
  output logic [N_STATION-1:0]          expired,
  output logic [N_STATION-1:0]          sat_err,
  output logic                          busy
`ifdef GAME_CREDIT_STATS_EN
  ,
  output logic [31:0]                   revenue,
  output logic [15:0]                   grant_cnt
`endif
);

  localparam int PTR_W = (N_STATION > 1) ? $clog2(N_STATION) : 1;
  localparam logic [CREDIT_W-1:0] WARN_C = CREDIT_W'(WARN_LEVEL);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_LOW  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  logic [PTR_W-1:0]    r_rr_ptr;
  logic [PTR_W-1:0]    w_idx;
  logic [PTR_W-1:0]    w_grant_idx;
  logic                w_found;
  logic [CREDIT_W-1:0] w_money_arr [N_STATION];
  logic [N_STATION-1:0] w_active;

  // NOTE: every variable gets a default before the loop, so no path leaves it unassigned (no latch).
  always_comb begin
    req_ready   = '0;
    w_found     = 1'b0;
    w_grant_idx = '0;
    w_idx       = '0;
    for (int k = 0; k < N_STATION; k++) begin
      w_idx = PTR_W'((int'(r_rr_ptr) + k) % N_STATION);
      if (!w_found && req_valid[w_idx]) begin
        req_ready[w_idx] = 1'b1;
        w_found          = 1'b1;
        w_grant_idx      = w_idx;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_found) begin
      r_rr_ptr <= (w_grant_idx == PTR_W'(N_STATION - 1)) ? '0 : w_grant_idx + PTR_W'(1);
    end
  end

  for (genvar i = 0; i < N_STATION; i++) begin : g_station
    state_t              r_state;
    state_t              w_state_nxt;
    logic [CREDIT_W-1:0] r_credit;
    logic [CREDIT_W-1:0] w_dec;
    logic [CREDIT_W-1:0] w_base;
    logic [CREDIT_W-1:0] w_money;
    logic [CREDIT_W-1:0] w_credit_nxt;
    logic [CREDIT_W:0]   w_sum;
    logic                r_sat;
    logic                w_burning;

    assign w_money_arr[i] = req_money[i*CREDIT_W +: CREDIT_W];
    assign w_burning      = (r_state == S_PLAY) || (r_state == S_LOW);

    // Burn saturates at zero first, then the granted top-up is added one bit wider.
    assign w_dec        = w_burning ? (boost[i] ? CREDIT_W'(2) : CREDIT_W'(1)) : '0;
    assign w_base       = (r_credit > w_dec) ? r_credit - w_dec : '0;
    assign w_money      = req_ready[i] ? w_money_arr[i] : '0;
    assign w_sum        = {1'b0, w_base} + {1'b0, w_money};
    assign w_credit_nxt = w_sum[CREDIT_W] ? '1 : w_sum[CREDIT_W-1:0];

    // Running out passes through OUT for one cycle; IDLE and OUT fall to IDLE when empty.
    always_comb begin
      w_state_nxt = S_IDLE;
      if (w_credit_nxt == '0) begin
        w_state_nxt = w_burning ? S_OUT : S_IDLE;
      end else if (w_credit_nxt < WARN_C) begin
        w_state_nxt = S_LOW;
      end else begin
        w_state_nxt = S_PLAY;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state  <= S_IDLE;
        r_credit <= '0;
        r_sat    <= 1'b0;
      end else begin
        r_state  <= w_state_nxt;
        r_credit <= w_credit_nxt;
        r_sat    <= w_sum[CREDIT_W];
      end
    end

    assign credit[i*CREDIT_W +: CREDIT_W] = r_credit;
    assign state[i*2 +: 2]                = r_state;
    assign low[i]                         = (r_state == S_LOW);
    assign expired[i]                     = (r_state == S_OUT);
    assign sat_err[i]                     = r_sat;
    assign w_active[i]                    = w_burning;
  end

  assign busy = |w_active;

`ifdef GAME_CREDIT_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      revenue   <= '0;
      grant_cnt <= '0;
    end else if (w_found) begin
      revenue   <= revenue + 32'(w_money_arr[w_grant_idx]);
      grant_cnt <= grant_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_game_credit_arbiter.sv
// Directed self-checking bench for game_credit_arbiter (N_STATION=4, CREDIT_W=10, WARN_LEVEL=10).
// Define GAME_CREDIT_STATS_EN for both files to also check the statistics outputs.
module tb_game_credit_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [39:0] req_money;
  logic [3:0]  req_ready;
  logic [3:0]  boost;
  logic [39:0] credit;
  logic [7:0]  state;
  logic [3:0]  low;
  logic [3:0]  expired;
  logic [3:0]  sat_err;
  logic        busy;
`ifdef GAME_CREDIT_STATS_EN
  logic [31:0] revenue;
  logic [15:0] grant_cnt;
`endif

  logic [9:0] mon [4];
  logic [9:0] cr  [4];
  logic [1:0] st  [4];

  int n_cmp = 0;
  int n_bad = 0;

  for (genvar g = 0; g < 4; g++) begin : g_lane
    assign req_money[g*10 +: 10] = mon[g];
    assign cr[g] = credit[g*10 +: 10];
    assign st[g] = state[g*2 +: 2];
  end

  game_credit_arbiter #(
    .N_STATION (4),
    .CREDIT_W  (10),
    .WARN_LEVEL(10)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_money(req_money),
    .req_ready(req_ready),
    .boost    (boost),
    .credit   (credit),
    .state    (state),
    .low      (low),
    .expired  (expired),
    .sat_err  (sat_err),
    .busy     (busy)
`ifdef GAME_CREDIT_STATS_EN
    ,
    .revenue  (revenue),
    .grant_cnt(grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    boost     = '0;
    for (int i = 0; i < 4; i++) mon[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (credit !== 40'd0) begin n_bad++; $display("FAIL reset_credit got %h want 0", credit); end
    n_cmp++; if (state !== 8'd0) begin n_bad++; $display("FAIL reset_state got %h want 0", state); end
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_ready got %b want 0000", req_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if ({low, expired, sat_err} !== 12'd0) begin n_bad++; $display("FAIL reset_flags got %h want 0", {low, expired, sat_err}); end
  endtask

  task automatic test_burn();
    logic [1:0] exp_st;
    req_valid = 4'b0001;
    mon[0]    = 10'd12;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL burn_grant got %b want 0001", req_ready); end
    tick();
    req_valid = '0;
    n_cmp++; if (cr[0] !== 10'd12) begin n_bad++; $display("FAIL burn_topup got %0d want 12", cr[0]); end
    n_cmp++; if (st[0] !== 2'd1) begin n_bad++; $display("FAIL burn_play got %0d want 1", st[0]); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL burn_busy got %b want 1", busy); end
    for (int c = 11; c >= 0; c--) begin
      tick();
      exp_st = (c == 0) ? 2'd3 : (c < 10) ? 2'd2 : 2'd1;
      n_cmp++; if (cr[0] !== 10'(c)) begin n_bad++; $display("FAIL burn_credit got %0d want %0d", cr[0], c); end
      n_cmp++; if (st[0] !== exp_st) begin n_bad++; $display("FAIL burn_state at %0d got %0d want %0d", c, st[0], exp_st); end
      n_cmp++; if (low[0] !== (exp_st == 2'd2)) begin n_bad++; $display("FAIL burn_low at %0d got %b", c, low[0]); end
      n_cmp++; if (expired[0] !== (c == 0)) begin n_bad++; $display("FAIL burn_expired at %0d got %b", c, expired[0]); end
    end
    tick();
    n_cmp++; if (st[0] !== 2'd0) begin n_bad++; $display("FAIL burn_idle got %0d want 0", st[0]); end
    n_cmp++; if (expired[0] !== 1'b0) begin n_bad++; $display("FAIL burn_pulse got %b want 0", expired[0]); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL burn_notbusy got %b want 0", busy); end
  endtask

  task automatic test_round_robin();
    logic [3:0] vv [5] = '{4'b1111, 4'b1110, 4'b1110, 4'b1010, 4'b0010};
    logic [3:0] er [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0010};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      req_valid = vv[k];
      #1;
      n_cmp++; if (req_ready !== er[k]) begin n_bad++; $display("FAIL rr_grant step %0d got %b want %b", k, req_ready, er[k]); end
      tick();
    end
    req_valid = '0;
    #1;
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL rr_idle got %b want 0000", req_ready); end
    n_cmp++; if (credit !== 40'd0) begin n_bad++; $display("FAIL rr_zero_money_credit got %h want 0", credit); end
    n_cmp++; if (state !== 8'd0) begin n_bad++; $display("FAIL rr_zero_money_state got %h want 0", state); end
`ifdef GAME_CREDIT_STATS_EN
    n_cmp++; if (grant_cnt !== 16'd5) begin n_bad++; $display("FAIL rr_grant_cnt got %0d want 5", grant_cnt); end
    n_cmp++; if (revenue !== 32'd0) begin n_bad++; $display("FAIL rr_revenue got %0d want 0", revenue); end
`endif
  endtask

  task automatic test_boost_underflow();
    do_reset();
    mon[2]    = 10'd1;
    req_valid = 4'b0100;
    #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL uf_grant got %b want 0100", req_ready); end
    tick();
    req_valid = '0;
    boost     = 4'b0100;
    n_cmp++; if (cr[2] !== 10'd1) begin n_bad++; $display("FAIL uf_topup got %0d want 1", cr[2]); end
    n_cmp++; if (st[2] !== 2'd2) begin n_bad++; $display("FAIL uf_low got %0d want 2", st[2]); end
    tick();
    n_cmp++; if (cr[2] !== 10'd0) begin n_bad++; $display("FAIL uf_credit got %0d want 0", cr[2]); end
    n_cmp++; if (st[2] !== 2'd3) begin n_bad++; $display("FAIL uf_out got %0d want 3", st[2]); end
    n_cmp++; if (expired !== 4'b0100) begin n_bad++; $display("FAIL uf_expired got %b want 0100", expired); end
    tick();
    boost = '0;
    n_cmp++; if (st[2] !== 2'd0 || cr[2] !== 10'd0) begin n_bad++; $display("FAIL uf_idle got st %0d cr %0d want 0 0", st[2], cr[2]); end
  endtask

  task automatic test_saturate();
    do_reset();
    mon[3]    = 10'd1020;
    req_valid = 4'b1000;
    tick();
    n_cmp++; if (cr[3] !== 10'd1020) begin n_bad++; $display("FAIL sat_load got %0d want 1020", cr[3]); end
    n_cmp++; if (st[3] !== 2'd1) begin n_bad++; $display("FAIL sat_play got %0d want 1", st[3]); end
    mon[3] = 10'd10;
    #1;
    n_cmp++; if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL sat_grant got %b want 1000", req_ready); end
    tick();
    req_valid = '0;
    boost     = 4'b1000;
    n_cmp++; if (cr[3] !== 10'd1023) begin n_bad++; $display("FAIL sat_clamp got %0d want 1023", cr[3]); end
    n_cmp++; if (sat_err !== 4'b1000) begin n_bad++; $display("FAIL sat_err_set got %b want 1000", sat_err); end
    tick();
    boost = '0;
    n_cmp++; if (sat_err !== 4'b0000) begin n_bad++; $display("FAIL sat_err_pulse got %b want 0000", sat_err); end
    n_cmp++; if (cr[3] !== 10'd1021) begin n_bad++; $display("FAIL sat_boost_burn got %0d want 1021", cr[3]); end
`ifdef GAME_CREDIT_STATS_EN
    n_cmp++; if (revenue !== 32'd1030) begin n_bad++; $display("FAIL sat_revenue got %0d want 1030", revenue); end
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    mon[0]    = 10'd50;
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    n_cmp++; if (cr[0] !== 10'd50 || st[0] !== 2'd1) begin n_bad++; $display("FAIL mid_load got cr %0d st %0d want 50 1", cr[0], st[0]); end
    tick();
    n_cmp++; if (cr[0] !== 10'd49) begin n_bad++; $display("FAIL mid_burn got %0d want 49", cr[0]); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (cr[0] !== 10'd0) begin n_bad++; $display("FAIL mid_async_credit got %0d want 0", cr[0]); end
    n_cmp++; if (st[0] !== 2'd0) begin n_bad++; $display("FAIL mid_async_state got %0d want 0", st[0]); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_async_busy got %b want 0", busy); end
    #1;
    rst_n = 1'b1;
    tick();
    n_cmp++; if (cr[0] !== 10'd0 || st[0] !== 2'd0) begin n_bad++; $display("FAIL mid_after got cr %0d st %0d want 0 0", cr[0], st[0]); end
  endtask

  initial begin
    test_reset();
    test_burn();
    test_round_robin();
    test_boost_underflow();
    test_saturate();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
